// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU arbiter controller and its ALU.
// Latency: none (declarations only).
// Backpressure: n/a. Optional multiply support is controlled by macro ALU_MUL_EN.
package alu_pkg;

   // Operation encodings carried on reqX_op
   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_MUL = 3'b100
   } alu_op_e;

   // Bit positions inside the 4-bit {N,Z,C,V} flag vector
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   // Controller sequencing states
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      MUL  = 2'b10,
      RESP = 2'b11
   } ctrl_state_e;

   // An op is legal if this build can execute it; MUL only with ALU_MUL_EN
   function automatic logic op_is_legal(input logic [2:0] op);
`ifdef ALU_MUL_EN
      return (op <= OP_MUL);
`else
      return (op <= OP_OR);
`endif
   endfunction

endpackage

// File: rtl/Alu.sv
// Combinational ALU: ADD/SUB/AND/OR with {N,Z,C,V} flags.
// Latency: zero (purely combinational).
// Backpressure: none. For SUB, C reports a borrow (A < B unsigned).
module Alu
   import alu_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic [1:0]   ALU_Sel,
   output logic [N-1:0] ALU_Result,
   output logic [3:0]   ALU_Flags
);

   logic [N:0] wide;
   logic       carry;
   logic       ovf;

   // Compute result plus carry/overflow for the selected operation
   always_comb begin
      wide       = '0;
      carry      = 1'b0;
      ovf        = 1'b0;
      ALU_Result = '0;
      case (ALU_Sel)
         2'b00: begin
            wide       = {1'b0, A} + {1'b0, B};
            ALU_Result = wide[N-1:0];
            carry      = wide[N];
            ovf        = (A[N-1] == B[N-1]) && (ALU_Result[N-1] != A[N-1]);
         end
         2'b01: begin
            wide       = {1'b0, A} - {1'b0, B};
            ALU_Result = wide[N-1:0];
            carry      = wide[N];
            ovf        = (A[N-1] != B[N-1]) && (ALU_Result[N-1] != A[N-1]);
         end
         2'b10:   ALU_Result = A & B;
         default: ALU_Result = A | B;
      endcase
   end

   // Pack flags in {N,Z,C,V} order
   always_comb begin
      ALU_Flags         = '0;
      ALU_Flags[FLAG_N] = ALU_Result[N-1];
      ALU_Flags[FLAG_Z] = (ALU_Result == '0);
      ALU_Flags[FLAG_C] = carry;
      ALU_Flags[FLAG_V] = ovf;
   end

endmodule

// File: rtl/alu_rr_arb.sv
// Two-way round-robin grant from requester valids and the last granted id.
// Latency: zero (combinational).
// Backpressure: none; the caller qualifies the grant with its own state.
module alu_rr_arb (
   input  logic [1:0] valid_i,
   input  logic       last_grant_i,
   output logic       grant_o
);

   // A lone requester wins; on a tie the one not granted last time wins
   always_comb begin
      grant_o = ~last_grant_i;
      case (valid_i)
         2'b01:   grant_o = 1'b0;
         2'b10:   grant_o = 1'b1;
         default: grant_o = ~last_grant_i;
      endcase
   end

endmodule

// File: rtl/alu_arbiter_ctrl.sv
// Shares one ALU between two requesters, round-robin, one operation outstanding.
// Latency: rsp_valid 2 clk after accept cycle (1 for illegal ops, N+1 for MUL).
// Backpressure: response held until rsp_ready; no new accept until it is taken.
// Optional multiply (op 100) is built only when macro ALU_MUL_EN is defined.
module alu_arbiter_ctrl
   import alu_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [N-1:0] req0_a,
   input  logic [N-1:0] req0_b,
   input  logic [2:0]   req0_op,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [N-1:0] req1_a,
   input  logic [N-1:0] req1_b,
   input  logic [2:0]   req1_op,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic         rsp_id,
   output logic [N-1:0] rsp_result,
   output logic [3:0]   rsp_flags,
   output logic         rsp_err,
   output logic         busy
);

   ctrl_state_e  state_q, state_d;
   logic         last_grant_q;
   logic         grant;
   logic         accept;

   logic [N-1:0] sel_a, sel_b;
   logic [2:0]   sel_op;

   logic [N-1:0] a_q, b_q;
   logic [1:0]   op_q;
   logic         id_q;

   logic [N-1:0] alu_a, alu_b, alu_res;
   logic [1:0]   alu_sel;
   logic [3:0]   alu_flags;

`ifdef ALU_MUL_EN
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   logic [N-1:0] acc_q;
   logic [CW-1:0] cnt_q;
   logic         mc_q;
   logic         mul_last;
   logic [3:0]   mul_flags;
`endif

   alu_rr_arb u_arb (
      .valid_i      ({req1_valid, req0_valid}),
      .last_grant_i (last_grant_q),
      .grant_o      (grant)
   );

   Alu #(.N(N)) u_alu (
      .A          (alu_a),
      .B          (alu_b),
      .ALU_Sel    (alu_sel),
      .ALU_Result (alu_res),
      .ALU_Flags  (alu_flags)
   );

   // Requester-facing outputs: handshake only in IDLE and out of reset
   always_comb begin
      req0_ready = !rst && (state_q == IDLE) && !grant && req0_valid;
      req1_ready = !rst && (state_q == IDLE) &&  grant && req1_valid;
      accept     = req0_ready || req1_ready;
      busy       = (state_q != IDLE);
      sel_a      = grant ? req1_a  : req0_a;
      sel_b      = grant ? req1_b  : req0_b;
      sel_op     = grant ? req1_op : req0_op;
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (!op_is_legal(sel_op))  state_d = RESP;
`ifdef ALU_MUL_EN
               else if (sel_op == OP_MUL) state_d = MUL;
`endif
               else                       state_d = EXEC;
            end
         end
         EXEC: state_d = RESP;
`ifdef ALU_MUL_EN
         MUL:  if (mul_last) state_d = RESP;
`endif
         RESP: if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ALU operand steering: latched operands, or the shift-add step during MUL
   always_comb begin
      alu_a   = a_q;
      alu_b   = b_q;
      alu_sel = op_q;
`ifdef ALU_MUL_EN
      if (state_q == MUL) begin
         alu_a   = acc_q;
         alu_b   = b_q[cnt_q] ? (a_q << cnt_q) : '0;
         alu_sel = 2'b00;
      end
`endif
   end

   // Latch the granted request and remember who won
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q          <= '0;
         b_q          <= '0;
         op_q         <= '0;
         id_q         <= 1'b0;
         last_grant_q <= 1'b1;
      end else if (accept) begin
         a_q          <= sel_a;
         b_q          <= sel_b;
         op_q         <= sel_op[1:0];
         id_q         <= grant;
         last_grant_q <= grant;
      end
   end

`ifdef ALU_MUL_EN
   assign mul_last = (cnt_q == CW'(N - 1));

   // Final multiply flags: carry is sticky across all partial-product adds
   always_comb begin
      mul_flags         = '0;
      mul_flags[FLAG_N] = alu_res[N-1];
      mul_flags[FLAG_Z] = (alu_res == '0);
      mul_flags[FLAG_C] = mc_q | alu_flags[FLAG_C];
   end

   // Multiply accumulator, bit counter and sticky carry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
         cnt_q <= '0;
         mc_q  <= 1'b0;
      end else if (accept) begin
         acc_q <= '0;
         cnt_q <= '0;
         mc_q  <= 1'b0;
      end else if (state_q == MUL) begin
         acc_q <= alu_res;
         cnt_q <= cnt_q + 1'b1;
         mc_q  <= mc_q | alu_flags[FLAG_C];
      end
   end
`endif

   // Response registers: loaded when a result is ready, cleared on handshake
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_result <= '0;
         rsp_flags  <= '0;
         rsp_err    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept && !op_is_legal(sel_op)) begin
                  rsp_valid  <= 1'b1;
                  rsp_id     <= grant;
                  rsp_result <= '0;
                  rsp_flags  <= '0;
                  rsp_err    <= 1'b1;
               end
            end
            EXEC: begin
               rsp_valid  <= 1'b1;
               rsp_id     <= id_q;
               rsp_result <= alu_res;
               rsp_flags  <= alu_flags;
               rsp_err    <= 1'b0;
            end
`ifdef ALU_MUL_EN
            MUL: begin
               if (mul_last) begin
                  rsp_valid  <= 1'b1;
                  rsp_id     <= id_q;
                  rsp_result <= alu_res;
                  rsp_flags  <= mul_flags;
                  rsp_err    <= 1'b0;
               end
            end
`endif
            RESP: begin
               if (rsp_ready) rsp_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// Randomized and directed stimulus checked against a transaction-level model.
// Latency: n/a.
// Backpressure: rsp_ready is driven both steadily and randomly.
module tb_alu_arbiter_ctrl;

   localparam int N = 4;
`ifdef ALU_MUL_EN
   localparam bit MUL_ON = 1'b1;
`else
   localparam bit MUL_ON = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         req0_valid, req0_ready, req1_valid, req1_ready;
   logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
   logic [2:0]   req0_op, req1_op;
   logic         rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
   logic [N-1:0] rsp_result;
   logic [3:0]   rsp_flags;

   always #5 clk = ~clk;

   alu_arbiter_ctrl #(.N(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_op    (req0_op),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_op    (req1_op),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_flags  (rsp_flags),
      .rsp_err    (rsp_err),
      .busy       (busy)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   typedef struct {
      int id;
      int res;
      int flg;
      int err;
      int lat;
   } exp_t;

   exp_t expq[$];
   int   acc_ids[$];
   bit   outst;
   int   age;
   bit   m_last;
   int   lr_res, lr_flg, lr_err, lr_id, lr_lat;

   // Expected response from arithmetic on the operands
   function automatic exp_t model(input int id, input int a, input int b, input int op);
      exp_t e;
      int r, c, v, sa, sb, s, acc, add;
      e.id = id; e.err = 0; r = 0; c = 0; v = 0;
      sa = (a >= 8) ? a - 16 : a;
      sb = (b >= 8) ? b - 16 : b;
      case (op)
         0: begin r = a + b; c = (r > 15) ? 1 : 0; s = sa + sb; v = (s > 7 || s < -8) ? 1 : 0; end
         1: begin r = (a - b) & 15; c = (a < b) ? 1 : 0; s = sa - sb; v = (s > 7 || s < -8) ? 1 : 0; end
         2: r = a & b;
         3: r = a | b;
         4: begin
            if (MUL_ON) begin
               acc = 0;
               for (int i = 0; i < N; i++) begin
                  add = ((b >> i) & 1) ? ((a << i) & 15) : 0;
                  if (acc + add > 15) c = 1;
                  acc = (acc + add) & 15;
               end
               r = acc;
            end else e.err = 1;
         end
         default: e.err = 1;
      endcase
      if (e.err != 0) begin
         e.res = 0; e.flg = 0; e.lat = 1;
      end else begin
         r     = r & 15;
         e.res = r;
         e.flg = ((r >= 8) ? 8 : 0) + ((r == 0) ? 4 : 0) + c * 2 + v;
         e.lat = (op == 4) ? N + 1 : 2;
      end
      return e;
   endfunction

   // One clock: drive inputs at the falling edge, check 1 time unit later
   task automatic cyc(input logic r, input logic v0, input logic [3:0] a0, input logic [3:0] b0,
                      input logic [2:0] op0, input logic v1, input logic [3:0] a1,
                      input logic [3:0] b1, input logic [2:0] op1, input logic rr);
      bit g, e0, e1, ev;
      rst = r; rsp_ready = rr;
      req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
      req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
      #1;
      if (r) begin
         chk("rst_ready0", req0_ready, 0);
         chk("rst_ready1", req1_ready, 0);
         chk("rst_busy", busy, 0);
         chk("rst_rsp_valid", rsp_valid, 0);
         chk("rst_rsp_id", rsp_id, 0);
         chk("rst_rsp_result", rsp_result, 0);
         chk("rst_rsp_flags", rsp_flags, 0);
         chk("rst_rsp_err", rsp_err, 0);
         outst = 0; expq.delete(); m_last = 1;
      end else begin
         if (outst) age++;
         g  = (v0 && v1) ? !m_last : v1;
         e0 = !outst && v0 && !g;
         e1 = !outst && v1 && g;
         chk("ready0", req0_ready, e0);
         chk("ready1", req1_ready, e1);
         chk("busy", busy, outst);
         ev = outst && (expq.size() > 0) && (age >= expq[0].lat);
         chk("rsp_valid", rsp_valid, ev);
         if (ev && rsp_valid) begin
            chk("rsp_id", rsp_id, expq[0].id);
            chk("rsp_result", rsp_result, expq[0].res);
            chk("rsp_flags", rsp_flags, expq[0].flg);
            chk("rsp_err", rsp_err, expq[0].err);
         end
         if (ev && rr) begin
            lr_res = rsp_result; lr_flg = rsp_flags; lr_err = rsp_err;
            lr_id = rsp_id; lr_lat = age;
            void'(expq.pop_front());
            outst = 0;
         end else if (e0 || e1) begin
            expq.push_back(model(g, g ? a1 : a0, g ? b1 : b0, g ? op1 : op0));
            acc_ids.push_back(g);
            m_last = g; outst = 1; age = 0;
         end
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n, input logic rr);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, rr);
   endtask

   task automatic do_reset();
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rst = 1; rsp_ready = 0;
      req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0;
      req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0;
      outst = 0; age = 0; m_last = 1;
      lr_res = 0; lr_flg = 0; lr_err = 0; lr_id = 0; lr_lat = 0;
      @(negedge clk);
      do_reset();

      // ADD 3+1 from req0
      cyc(0, 1, 4'd3, 4'd1, 3'b000, 0, 0, 0, 0, 1);
      idle(3, 1);
      chk("t1_result", lr_res, 4);
      chk("t1_flags", lr_flg, 0);
      chk("t1_id", lr_id, 0);
      chk("t1_err", lr_err, 0);
      chk("t1_latency", lr_lat, 2);

      // Both requesters valid: grants alternate starting with req0
      do_reset();
      acc_ids.delete();
      for (int i = 0; i < 18; i++) cyc(0, 1, 4'(i), 4'd2, 3'b000, 1, 4'(i + 5), 4'd1, 3'b001, 1);
      idle(2, 1);
      chk("t2_count", acc_ids.size(), 6);
      for (int i = 0; i < 6 && i < acc_ids.size(); i++) chk("t2_order", acc_ids[i], i % 2);

      // 0+0 held under backpressure while req1 waits
      cyc(0, 1, 4'd0, 4'd0, 3'b000, 0, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0, 1, 4'd7, 4'd7, 3'b011, 0);
      cyc(0, 0, 0, 0, 0, 1, 4'd7, 4'd7, 3'b011, 1);
      chk("t3_result", lr_res, 0);
      chk("t3_flags", lr_flg, 4'b0100);
      idle(4, 1);

      // Illegal op 111
      cyc(0, 1, 4'd9, 4'd9, 3'b111, 0, 0, 0, 0, 1);
      idle(2, 1);
      chk("t4_err", lr_err, 1);
      chk("t4_result", lr_res, 0);
      chk("t4_flags", lr_flg, 0);
      chk("t4_latency", lr_lat, 1);

      // MUL 3*5
      cyc(0, 0, 0, 0, 0, 1, 4'd3, 4'd5, 3'b100, 1);
      idle(N + 2, 1);
`ifdef ALU_MUL_EN
      chk("t5_result", lr_res, 4'b1111);
      chk("t5_flags", lr_flg, 4'b1000);
      chk("t5_latency", lr_lat, N + 1);
`else
      chk("t5_err", lr_err, 1);
      chk("t5_latency", lr_lat, 1);
`endif

      // Reset during execution, then a tie goes to req0
      cyc(0, 0, 0, 0, 0, 1, 4'd2, 4'd3, 3'b000, 1);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      idle(2, 1);
      cyc(0, 1, 4'd6, 4'd3, 3'b100, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      idle(2, 1);
      acc_ids.delete();
      cyc(0, 1, 4'd1, 4'd1, 3'b010, 1, 4'd1, 4'd1, 3'b011, 1);
      chk("t6_tie_grant", (acc_ids.size() > 0) ? acc_ids[0] : 9, 0);
      idle(3, 1);

      // Random traffic with random backpressure and occasional reset
      for (int i = 0; i < 600; i++) begin
         logic rr_r, r_r;
         r_r  = ($urandom_range(0, 99) == 0);
         rr_r = ($urandom_range(0, 99) < 70);
         cyc(r_r,
             ($urandom_range(0, 99) < 60), 4'($urandom), 4'($urandom),
             3'(($urandom_range(0, 9) < 8) ? $urandom_range(0, 4) : $urandom_range(5, 7)),
             ($urandom_range(0, 99) < 60), 4'($urandom), 4'($urandom),
             3'(($urandom_range(0, 9) < 8) ? $urandom_range(0, 4) : $urandom_range(5, 7)),
             rr_r);
      end
      idle(N + 4, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
